alarm_bank: RTL and testbench

- Multi-channel alarm engine for the digital clock top, replacing the single hard-wired alarm register.
- Holds NUM_ALARMS alarm slots, each with a programmable BCD time, enable and one-shot/daily mode.
- Compares every slot against the running clock once per second and drives a single ring/snooze/dismiss state machine that feeds the light/buzzer driver.
- Time format everywhere is the clock's 20-bit packed BCD: hou_h[19:18], hou_l[17:14], min_h[13:11], min_l[10:7], sec_h[6:4], sec_l[3:0].

---
 rtl/alarm_bank.sv | 186 ++++++++++++++++++
 tb/tb_alarm_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank.sv
// Multi-slot alarm engine: per-slot BCD alarm times, once-per-second match
// detection and a ring/snooze/dismiss controller driving the buzzer/light.
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    localparam int IW  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int RCW = $clog2(RING_SECS + 1),
    localparam int SCW = $clog2(SNOOZE_SECS + 1),
    localparam int UCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [19:0]           cur_time,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [19:0]           wr_time,
    input  logic                  wr_enable,
    input  logic                  wr_oneshot,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  ring,
    output logic                  snoozed,
    output logic [IW-1:0]         ring_idx,
    output logic [NUM_ALARMS-1:0] pending,
    output logic [NUM_ALARMS-1:0] en_mask,
    output logic                  missed,
    output logic                  wr_err
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    // Hours 00..23, minutes/seconds 00..59, every digit a decimal digit.
    function automatic logic time_legal(input logic [19:0] t);
        logic [1:0] hh;
        logic [3:0] hl, ml, sl;
        logic [2:0] mh, sh;
        hh = t[19:18]; hl = t[17:14]; mh = t[13:11];
        ml = t[10:7];  sh = t[6:4];   sl = t[3:0];
        return (hh <= 2'd2) && (hl <= 4'd9) && !((hh == 2'd2) && (hl > 4'd3)) &&
               (mh <= 3'd5) && (ml <= 4'd9) && (sh <= 3'd5) && (sl <= 4'd9);
    endfunction

    logic [19:0]           slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] oneshot;

    state_t                state, state_nx;
    logic [IW-1:0]         ring_idx_nx;
    logic [RCW-1:0]        ring_cnt, ring_cnt_nx;
    logic [SCW-1:0]        sleep_cnt, sleep_cnt_nx;
    logic [UCW-1:0]        used_cnt, used_cnt_nx;
    logic                  missed_nx;

    logic                  wr_ok;
    logic                  abort;
    logic [IW-1:0]         pick_idx;
    logic [NUM_ALARMS-1:0] clr_mask;
    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] pending_nx, en_mask_nx;

    assign wr_ok = wr_en && (int'(wr_idx) < NUM_ALARMS) && time_legal(wr_time);
    // Rewriting the slot that is sounding silences it without counting as missed.
    assign abort = wr_ok && (wr_idx == ring_idx);

    always_comb begin
        match    = '0;
        pick_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            match[i] = tick_1hz && en_mask[i] && (slot_time[i] == cur_time);
            if (pending[i]) pick_idx = IW'(i);
        end
    end

    always_comb begin
        state_nx     = state;
        ring_idx_nx  = ring_idx;
        ring_cnt_nx  = ring_cnt;
        sleep_cnt_nx = sleep_cnt;
        used_cnt_nx  = used_cnt;
        missed_nx    = 1'b0;
        clr_mask     = '0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nx          = RING;
                    ring_idx_nx       = pick_idx;
                    clr_mask[pick_idx] = 1'b1;
                    ring_cnt_nx       = RCW'(RING_SECS);
                    used_cnt_nx       = '0;
                end
            end
            RING: begin
                if (abort || dismiss) begin
                    state_nx = IDLE;
                end else if (snooze) begin
                    if (used_cnt < UCW'(MAX_SNOOZE)) begin
                        state_nx     = SNOOZE;
                        sleep_cnt_nx = SCW'(SNOOZE_SECS);
                        used_cnt_nx  = used_cnt + UCW'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (tick_1hz) begin
                    if (ring_cnt <= RCW'(1)) begin
                        state_nx  = IDLE;
                        missed_nx = 1'b1;
                    end else begin
                        ring_cnt_nx = ring_cnt - RCW'(1);
                    end
                end
            end
            SNOOZE: begin
                if (abort || dismiss) begin
                    state_nx = IDLE;
                end else if (tick_1hz) begin
                    if (sleep_cnt <= SCW'(1)) begin
                        state_nx    = RING;
                        ring_cnt_nx = RCW'(RING_SECS);
                    end else begin
                        sleep_cnt_nx = sleep_cnt - SCW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Service-clear, then fresh matches, then a same-cycle write wins outright.
    always_comb begin
        pending_nx = pending & ~clr_mask;
        en_mask_nx = en_mask;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (match[i]) begin
                pending_nx[i] = 1'b1;
                if (oneshot[i]) en_mask_nx[i] = 1'b0;
            end
            if (wr_ok && (wr_idx == IW'(i))) begin
                pending_nx[i] = 1'b0;
                en_mask_nx[i] = wr_enable;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= '0;
            oneshot   <= '0;
            en_mask   <= '0;
            pending   <= '0;
            wr_err    <= 1'b0;
        end else begin
            if (wr_ok) begin
                slot_time[wr_idx] <= wr_time;
                oneshot[wr_idx]   <= wr_oneshot;
            end
            en_mask <= en_mask_nx;
            pending <= pending_nx;
            wr_err  <= wr_en && !wr_ok;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ring_idx  <= '0;
            ring_cnt  <= '0;
            sleep_cnt <= '0;
            used_cnt  <= '0;
            missed    <= 1'b0;
            ring      <= 1'b0;
            snoozed   <= 1'b0;
        end else begin
            state     <= state_nx;
            ring_idx  <= ring_idx_nx;
            ring_cnt  <= ring_cnt_nx;
            sleep_cnt <= sleep_cnt_nx;
            used_cnt  <= used_cnt_nx;
            missed    <= missed_nx;
            ring      <= (state_nx == RING);
            snoozed   <= (state_nx == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: write-validation table plus hand-written
// ring/snooze/timeout/priority/reset sequences.
module tb_alarm_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [19:0] cur_time = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [19:0] wr_time = '0;
    logic        wr_enable = 1'b0;
    logic        wr_oneshot = 1'b0;
    logic        snooze = 1'b0;
    logic        dismiss = 1'b0;
    logic        ring, snoozed, missed, wr_err;
    logic [1:0]  ring_idx;
    logic [3:0]  pending, en_mask;

    // Second instance with a non-power-of-two slot count for index rejection.
    logic        w5_en = 1'b0;
    logic [2:0]  w5_idx = '0;
    logic        ring5, snoozed5, missed5, wr_err5;
    logic [2:0]  ring_idx5;
    logic [4:0]  pending5, en_mask5;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alarm_bank dut (
        .clk_sys(clk), .rst(rst), .tick_1hz(tick), .cur_time(cur_time),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time),
        .wr_enable(wr_enable), .wr_oneshot(wr_oneshot),
        .snooze(snooze), .dismiss(dismiss),
        .ring(ring), .snoozed(snoozed), .ring_idx(ring_idx),
        .pending(pending), .en_mask(en_mask), .missed(missed), .wr_err(wr_err)
    );

    alarm_bank #(.NUM_ALARMS(5)) dut5 (
        .clk_sys(clk), .rst(rst), .tick_1hz(1'b0), .cur_time(20'd0),
        .wr_en(w5_en), .wr_idx(w5_idx), .wr_time(wr_time),
        .wr_enable(wr_enable), .wr_oneshot(wr_oneshot),
        .snooze(1'b0), .dismiss(1'b0),
        .ring(ring5), .snoozed(snoozed5), .ring_idx(ring_idx5),
        .pending(pending5), .en_mask(en_mask5), .missed(missed5), .wr_err(wr_err5)
    );

    function automatic logic [19:0] pack(input int hh, hl, mh, ml, sh, sl);
        logic [1:0] a; logic [3:0] b, d, f; logic [2:0] c, e;
        a = hh[1:0]; b = hl[3:0]; c = mh[2:0]; d = ml[3:0]; e = sh[2:0]; f = sl[3:0];
        return {a, b, c, d, e, f};
    endfunction

    function automatic logic [19:0] bcd(input int h, m, s);
        return pack(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en = 1'b0; w5_en = 1'b0; tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [19:0] t, input logic en, input logic os);
        wr_en = 1'b1; wr_idx = idx; wr_time = t; wr_enable = en; wr_oneshot = os;
        cyc();
    endtask

    task automatic tk(input logic [19:0] t);
        cur_time = t; tick = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic [19:0] t;
        logic        en;
        logic [3:0]  exp_en;
        logic        exp_err;
    } wvec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        wvec_t vt [8];
        logic  bad;
        logic [19:0] t_off, t_730, t_12;

        t_off = bcd(1, 2, 3);
        t_730 = bcd(7, 30, 0);
        t_12  = bcd(12, 0, 0);

        vt[0] = '{2'd0, bcd(23, 59, 59), 1'b1, 4'b0001, 1'b0};
        vt[1] = '{2'd1, bcd(24, 0, 0),   1'b1, 4'b0001, 1'b1};
        vt[2] = '{2'd1, bcd(12, 60, 0),  1'b1, 4'b0001, 1'b1};
        vt[3] = '{2'd1, pack(1, 2, 0, 10, 0, 0), 1'b1, 4'b0001, 1'b1};
        vt[4] = '{2'd1, bcd(12, 0, 60),  1'b1, 4'b0001, 1'b1};
        vt[5] = '{2'd1, bcd(30, 0, 0),   1'b1, 4'b0001, 1'b1};
        vt[6] = '{2'd1, bcd(19, 0, 0),   1'b1, 4'b0011, 1'b0};
        vt[7] = '{2'd0, bcd(0, 0, 0),    1'b0, 4'b0010, 1'b0};

        // Reset state
        cyc(); cyc();
        check("rst_ring", ring, 0);
        check("rst_snoozed", snoozed, 0);
        check("rst_pending", pending, 0);
        check("rst_en_mask", en_mask, 0);
        check("rst_ring_idx", ring_idx, 0);
        check("rst_missed", missed, 0);
        check("rst_wr_err", wr_err, 0);
        rst = 1'b0;
        cyc();

        // Write validation table
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].idx, vt[i].t, vt[i].en, 1'b0);
            check($sformatf("wtab%0d_err", i), wr_err, vt[i].exp_err);
            check($sformatf("wtab%0d_en", i), en_mask, vt[i].exp_en);
        end
        cyc();
        check("wr_err_one_cycle", wr_err, 0);

        // Wrong index on the 5-slot instance
        wr_time = bcd(6, 0, 0); wr_enable = 1'b1; wr_oneshot = 1'b0;
        w5_en = 1'b1; w5_idx = 3'd5; cyc();
        check("idx5_err", wr_err5, 1);
        check("idx5_en", en_mask5, 5'b00000);
        w5_en = 1'b1; w5_idx = 3'd4; cyc();
        check("idx4_err", wr_err5, 0);
        check("idx4_en", en_mask5, 5'b10000);
        w5_en = 1'b1; w5_idx = 3'd7; cyc();
        check("idx7_err", wr_err5, 1);
        check("idx7_en", en_mask5, 5'b10000);

        // Fresh start, basic trigger of slot 2
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(2'd2, t_730, 1'b1, 1'b0);
        tk(t_730);
        check("trig_pending", pending, 4'b0100);
        check("trig_ring_early", ring, 0);
        cur_time = t_off; cyc();
        check("trig_ring", ring, 1);
        check("trig_idx", ring_idx, 2);
        check("trig_pending_clr", pending, 0);
        check("trig_daily_en", en_mask, 4'b0100);

        // Snooze cycle and snooze exhaustion
        for (int n = 1; n <= 4; n++) begin
            snooze = 1'b1; cyc();
            if (n < 4) begin
                check($sformatf("snz%0d_snoozed", n), {ring, snoozed}, 2'b01);
                bad = 1'b0;
                for (int k = 1; k <= 300; k++) begin
                    tk(t_off);
                    if (k < 300 && (snoozed !== 1'b1 || ring !== 1'b0)) bad = 1'b1;
                end
                check($sformatf("snz%0d_hold", n), bad, 0);
                check($sformatf("snz%0d_rering", n), {ring, snoozed}, 2'b10);
                check($sformatf("snz%0d_idx", n), ring_idx, 2);
            end else begin
                check("snz_exhaust", {ring, snoozed}, 2'b00);
            end
        end

        // Ring timeout
        tk(t_730);
        cur_time = t_off; cyc();
        check("to_ring", ring, 1);
        bad = 1'b0;
        for (int k = 1; k <= 59; k++) begin
            tk(t_off);
            if (missed !== 1'b0 || ring !== 1'b1) bad = 1'b1;
        end
        check("to_hold59", bad, 0);
        tk(t_off);
        check("to_missed", missed, 1);
        check("to_ring_off", ring, 0);
        cyc();
        check("to_missed_pulse", missed, 0);
        check("to_idle", ring, 0);

        // One-shot slot clears its enable on trigger
        wr(2'd0, bcd(8, 0, 0), 1'b1, 1'b1);
        check("os_en_set", en_mask, 4'b0101);
        tk(bcd(8, 0, 0));
        check("os_pending", pending, 4'b0001);
        check("os_en_clr", en_mask, 4'b0100);
        cyc();
        check("os_ring_idx", {ring, ring_idx}, 3'b100);
        dismiss = 1'b1; cyc();
        check("os_dismiss", ring, 0);

        // Two slots on one tick: serviced in index order
        wr(2'd1, t_12, 1'b1, 1'b0);
        wr(2'd3, t_12, 1'b1, 1'b0);
        tk(t_12);
        check("dual_pending", pending, 4'b1010);
        cyc();
        check("dual_first", {ring, ring_idx}, 3'b101);
        check("dual_pend1", pending, 4'b1000);
        dismiss = 1'b1; snooze = 1'b1; tick = 1'b1; cur_time = t_off; cyc();
        check("dual_dismiss_prio", {ring, snoozed}, 2'b00);
        cyc();
        check("dual_second", {ring, ring_idx}, 3'b111);
        check("dual_pend0", pending, 0);
        dismiss = 1'b1; cyc();

        // Write to a slot on the tick it matches: write wins
        wr_en = 1'b1; wr_idx = 2'd3; wr_time = t_12; wr_enable = 1'b1; wr_oneshot = 1'b0;
        tk(t_12);
        check("wrm_pending", pending, 4'b0010);
        check("wrm_en", en_mask, 4'b1110);
        check("wrm_err", wr_err, 0);
        cyc();
        dismiss = 1'b1; cyc();

        // Legal write to the active slot forces IDLE without missed
        tk(t_12);
        cyc();
        check("abort_ring", {ring, ring_idx}, 3'b101);
        wr(2'd1, bcd(13, 0, 0), 1'b1, 1'b0);
        check("abort_idle", {ring, snoozed}, 2'b00);
        check("abort_missed", missed, 0);
        cyc();
        check("abort_next", {ring, ring_idx}, 3'b111);
        tk(t_12);
        check("retrig_active", pending, 4'b1000);

        // Asynchronous reset mid-RING
        #2 rst = 1'b1;
        #1;
        check("arst_ring", {ring, snoozed}, 2'b00);
        check("arst_pending", pending, 0);
        check("arst_en", en_mask, 0);
        cyc(); rst = 1'b0;

        // Asynchronous reset mid-SNOOZE
        wr(2'd2, t_730, 1'b1, 1'b0);
        tk(t_730);
        cur_time = t_off; cyc();
        snooze = 1'b1; cyc();
        check("pre_arst_snz", snoozed, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_snoozed", {ring, snoozed}, 2'b00);
        check("arst_en2", en_mask, 0);
        check("arst_idx", ring_idx, 0);
        cyc(); rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
